// File: rtl/mmio_sched_pkg.sv
// Shared types and constants for the MMIO port scheduler.
package mmio_sched_pkg;

    localparam int unsigned PORT_EXPONENT_DEF = 2;
    localparam int unsigned PORT_COUNT        = 2 ** PORT_EXPONENT_DEF;
    localparam int unsigned STAT_W            = 16;
    localparam int unsigned STAT_VALID_BIT    = 15;
    localparam int unsigned STAT_SERVICE_BIT  = 14;
    localparam int unsigned PORT_IDX_MAX_W    = 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_SERVICE = 2'd2,
        S_HOLDOFF = 2'd3
    } sched_state_t;

    // Assemble the CPU-visible status word; unused bits stay zero.
    function automatic logic [STAT_W-1:0] make_status(
        input logic                      valid,
        input logic                      service,
        input logic [PORT_IDX_MAX_W-1:0] port
    );
        logic [STAT_W-1:0] w;
        w                            = '0;
        w[STAT_VALID_BIT]            = valid;
        w[STAT_SERVICE_BIT]          = service;
        w[PORT_IDX_MAX_W-1:0]        = port;
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational find-first-set over 2**W request bits, searching upward from ptr with wrap.
module rr_priority_picker #(
    parameter int unsigned W = 2
) (
    input  logic [(2**W)-1:0] req,
    input  logic [W-1:0]      ptr,
    output logic              found,
    output logic [W-1:0]      index
);

    localparam int unsigned N = 2 ** W;

    logic [W-1:0] cand;

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        found = |req;
        index = ptr;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = W'(ptr + W'(i));
            if (req[cand]) begin
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mmio_port_scheduler.sv
// Round-robin service scheduler for peripheral ports with CPU claim/done handshake.
module mmio_port_scheduler
    import mmio_sched_pkg::*;
#(
    parameter int unsigned PORT_EXPONENT  = PORT_EXPONENT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(2**PORT_EXPONENT)-1:0] port_req,
    input  logic                        claim,
    input  logic                        done,
    output logic                        grant_valid,
    output logic [PORT_EXPONENT-1:0]    grant_port,
    output logic [(2**PORT_EXPONENT)-1:0] grant_onehot,
    output logic [STAT_W-1:0]           status_word,
    output logic [(2**PORT_EXPONENT)-1:0] pending,
    output logic [7:0]                  timeout_count
);

    localparam int unsigned NPORT  = 2 ** PORT_EXPONENT;
    localparam int unsigned TMO_W  = 16;
    localparam int unsigned HOLD_W = 4;

    sched_state_t             state;
    logic [NPORT-1:0]         req_q;
    logic [NPORT-1:0]         rise;
    logic [NPORT-1:0]         pend_clr;
    logic [PORT_EXPONENT-1:0] rr_ptr;
    logic [TMO_W-1:0]         tmo_cnt;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     pick_found;
    logic [PORT_EXPONENT-1:0] pick_idx;

    assign rise = port_req & ~req_q;

    // Completion clears the serviced port's pending bit.
    always_comb begin
        pend_clr = '0;
        if (state == S_SERVICE && done) begin
            pend_clr[grant_port] = 1'b1;
        end
    end

    // A new rising edge wins over a same-cycle completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= port_req;
            pending <= (pending & ~pend_clr) | rise;
        end
    end

    rr_priority_picker #(
        .W(PORT_EXPONENT)
    ) u_picker (
        .req  (pending),
        .ptr  (rr_ptr),
        .found(pick_found),
        .index(pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant_valid   <= 1'b0;
            grant_port    <= '0;
            grant_onehot  <= '0;
            status_word   <= '0;
            timeout_count <= '0;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
            hold_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (pick_found) begin
                        state        <= S_OFFER;
                        grant_valid  <= 1'b1;
                        grant_port   <= pick_idx;
                        grant_onehot <= NPORT'(1) << pick_idx;
                        status_word  <= make_status(1'b1, 1'b0, PORT_IDX_MAX_W'(pick_idx));
                    end
                end
                S_OFFER: begin
                    if (claim) begin
                        state       <= S_SERVICE;
                        status_word <= make_status(1'b1, 1'b1, PORT_IDX_MAX_W'(grant_port));
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Withdraw the offer; the request stays pending for a later pass.
                        state        <= S_IDLE;
                        grant_valid  <= 1'b0;
                        grant_port   <= '0;
                        grant_onehot <= '0;
                        status_word  <= '0;
                        rr_ptr       <= grant_port + PORT_EXPONENT'(1);
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_SERVICE: begin
                    if (done) begin
                        state        <= (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
                        grant_valid  <= 1'b0;
                        grant_port   <= '0;
                        grant_onehot <= '0;
                        status_word  <= '0;
                        rr_ptr       <= grant_port + PORT_EXPONENT'(1);
                        hold_cnt     <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_scheduler.sv
// Directed and randomized checks of mmio_port_scheduler against a timestamp-based reference model.
module tb_mmio_port_scheduler;

    localparam int unsigned PE   = 2;
    localparam int unsigned NP   = 4;
    localparam int unsigned TMO  = 4;
    localparam int unsigned HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] port_req;
    logic          claim;
    logic          done;
    logic          grant_valid;
    logic [PE-1:0] grant_port;
    logic [NP-1:0] grant_onehot;
    logic [15:0]   status_word;
    logic [NP-1:0] pending;
    logic [7:0]    timeout_count;

    int checks = 0;
    int errors = 0;
    logic [NP-1:0] cur_req = '0;

    mmio_port_scheduler #(
        .PORT_EXPONENT (PE),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_req     (port_req),
        .claim        (claim),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_port   (grant_port),
        .grant_onehot (grant_onehot),
        .status_word  (status_word),
        .pending      (pending),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Reference model: current grant (-1 = none), and the edge number from which a new pick is allowed.
    int            m_cur;
    bit            m_claimed;
    int            m_age;
    int            m_idle_from;
    int            m_edge;
    bit            m_pend [NP];
    int            m_rr;
    int            m_tmo;
    logic [NP-1:0] m_req_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < NP; i++) begin
            if (m_pend[(m_rr + i) % NP]) return (m_rr + i) % NP;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = -1; m_claimed = 0; m_age = 0; m_idle_from = 0; m_edge = 0;
        m_rr = 0; m_tmo = 0; m_req_prev = '0;
        for (int i = 0; i < NP; i++) m_pend[i] = 0;
    endtask

    task automatic model_step(input logic [NP-1:0] req, input logic clm, input logic dn);
        int p;
        m_edge++;
        if (m_cur < 0) begin
            p = pick();
            if (m_edge >= m_idle_from && p >= 0) begin
                m_cur = p; m_claimed = 0; m_age = 0;
            end
        end else if (!m_claimed) begin
            if (clm) m_claimed = 1;
            else begin
                m_age++;
                if (m_age == TMO) begin
                    m_rr = (m_cur + 1) % NP;
                    if (m_tmo < 255) m_tmo++;
                    m_cur = -1;
                    m_idle_from = m_edge + 1;
                end
            end
        end else if (dn) begin
            m_pend[m_cur] = 0;
            m_rr = (m_cur + 1) % NP;
            m_cur = -1;
            m_idle_from = m_edge + HOLD + 1;
        end
        for (int i = 0; i < NP; i++) begin
            if (req[i] && !m_req_prev[i]) m_pend[i] = 1;
        end
        m_req_prev = req;
    endtask

    task automatic check_outputs();
        logic [31:0] e_stat, e_oh, e_pend;
        e_stat = 0; e_oh = 0; e_pend = 0;
        if (m_cur >= 0) begin
            e_stat = 32'h8000 | (m_claimed ? 32'h4000 : 32'h0) | 32'(m_cur);
            e_oh   = 32'h1 << m_cur;
        end
        for (int i = 0; i < NP; i++) if (m_pend[i]) e_pend = e_pend | (32'h1 << i);
        check("grant_valid", 32'(grant_valid), (m_cur >= 0) ? 32'd1 : 32'd0);
        check("grant_port", 32'(grant_port), (m_cur >= 0) ? 32'(m_cur) : 32'd0);
        check("grant_onehot", 32'(grant_onehot), e_oh);
        check("status_word", 32'(status_word), e_stat);
        check("pending", 32'(pending), e_pend);
        check("timeout_count", 32'(timeout_count), 32'(m_tmo));
    endtask

    task automatic tick(input logic clm, input logic dn);
        claim = clm; done = dn; port_req = cur_req;
        @(posedge clk);
        model_step(cur_req, clm, dn);
        #1;
        claim = 1'b0; done = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        port_req = cur_req; claim = 1'b0; done = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!grant_valid && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check("wait_grant", 32'(grant_valid), 32'd1);
    endtask

    task automatic serve(input int p);
        wait_grant();
        check("serve_port", 32'(grant_port), 32'(p));
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; claim = 1'b0; done = 1'b0; port_req = '0;
        model_reset();

        // Single request: offer two cycles after the edge, then claim/done and holdoff.
        cur_req = '0; do_reset();
        check("rst_status", 32'(status_word), 32'h0);
        cur_req = 4'b0100; tick(1'b0, 1'b0);
        check("t1_pend", 32'(pending), 32'h4);
        check("t1_valid_k", 32'(grant_valid), 32'd0);
        tick(1'b0, 1'b0);
        check("t1_valid", 32'(grant_valid), 32'd1);
        check("t1_port", 32'(grant_port), 32'd2);
        tick(1'b1, 1'b0);
        check("t1_status_svc", 32'(status_word), 32'hC002);
        tick(1'b0, 1'b1);
        check("t1_pend_clr", 32'(pending), 32'h0);
        check("t1_valid_done", 32'(grant_valid), 32'd0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);

        // Round robin over 0,1,3 then wrap back to 0.
        cur_req = '0; do_reset();
        cur_req = 4'b1011; tick(1'b0, 1'b0);
        serve(0); serve(1); serve(3);
        cur_req = '0; tick(1'b0, 1'b0);
        cur_req = 4'b0001; tick(1'b0, 1'b0);
        wait_grant();
        check("t2_wrap_port", 32'(grant_port), 32'd0);

        // Timeout with another port pending: next offer goes to port 2.
        cur_req = '0; do_reset();
        cur_req = 4'b0010; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("t3_port1", 32'(grant_port), 32'd1);
        cur_req = 4'b0110;
        repeat (3) tick(1'b0, 1'b0);
        check("t3_still_valid", 32'(grant_valid), 32'd1);
        tick(1'b0, 1'b0);
        check("t3_withdrawn", 32'(grant_valid), 32'd0);
        check("t3_tmo_count", 32'(timeout_count), 32'd1);
        tick(1'b0, 1'b0);
        check("t3_next_port", 32'(grant_port), 32'd2);

        // Timeout alone: the same port is re-offered.
        cur_req = '0; do_reset();
        cur_req = 4'b0010; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        check("t3b_withdrawn", 32'(grant_valid), 32'd0);
        tick(1'b0, 1'b0);
        check("t3b_reoffer", 32'(grant_port), 32'd1);
        check("t3b_reoffer_v", 32'(grant_valid), 32'd1);

        // New edge on the serviced port coinciding with done keeps it pending.
        cur_req = '0; do_reset();
        cur_req = 4'b1000; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        cur_req = '0; tick(1'b0, 1'b0);
        cur_req = 4'b1000; tick(1'b0, 1'b1);
        check("t4_pend_kept", 32'(pending), 32'h8);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("t4_holdoff", 32'(grant_valid), 32'd0);
        tick(1'b0, 1'b0);
        check("t4_reoffer", 32'(grant_port), 32'd3);
        check("t4_reoffer_v", 32'(grant_valid), 32'd1);

        // done alone is ignored in OFFER; claim+done counts as claim only.
        cur_req = '0; do_reset();
        cur_req = 4'b0100; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("t5_done_ignored", 32'(status_word), 32'h8002);
        tick(1'b1, 1'b1);
        check("t5_claim_wins", 32'(status_word), 32'hC002);
        check("t5_pend_same", 32'(pending), 32'h4);

        // Reset mid-service, request held through release gives a fresh offer.
        do_reset();
        check("t6_valid0", 32'(grant_valid), 32'd0);
        check("t6_pend0", 32'(pending), 32'h0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("t6_reoffer", 32'(grant_port), 32'd2);
        check("t6_reoffer_v", 32'(grant_valid), 32'd1);

        // Randomized traffic with occasional resets.
        cur_req = '0; do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [NP-1:0] flip;
            flip = '0;
            for (int b = 0; b < NP; b++) flip[b] = ($urandom_range(0, 7) == 0);
            cur_req = cur_req ^ flip;
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mmio_port_scheduler.md
# mmio_port_scheduler

Services peripheral ports sitting behind `mmio_controller`: latches per-port service requests, picks one with a round-robin policy and offers it to the CPU through a 16-bit status word. It then tracks the CPU's claim/done handshake until the port has been serviced. It sits between the peripheral port bank and the MMIO read path. The CPU polls `status_word`, services the named port pair through `mmio_controller`, then pulses `done`.

## Interface
Parameters:
- `PORT_EXPONENT`, default `` `PORT_EXPONENT `` (from `src/parameters.svh`): port count is 2**PORT_EXPONENT; supported range 1..7.
- `TIMEOUT_CYCLES`, default 255: OFFER cycles allowed without a claim before the offer is withdrawn; range 1..65535.
- `HOLDOFF_CYCLES`, default 2: idle gap after each completed service; range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `port_req` in PORT_COUNT: level request per port; a rising edge means new work.
- `claim` in 1: one-cycle pulse; CPU accepts the current offer.
- `done` in 1: one-cycle pulse; CPU has finished servicing the claimed port.
- `grant_valid` out 1: an offer or service is active (OFFER or SERVICE).
- `grant_port` out PORT_EXPONENT: index of the offered or claimed port.
- `grant_onehot` out PORT_COUNT: one-hot of `grant_port`, qualified by `grant_valid`.
- `status_word` out 16: bit15 = grant_valid, bit14 = in SERVICE, bits[PORT_EXPONENT-1:0] = grant_port, all other bits 0.
- `pending` out PORT_COUNT: latched request bits.
- `timeout_count` out 8: saturating count of withdrawn offers.

## Operation
- Edge detect: `req_q` is registered `port_req` and resets to 0. On an edge where `port_req[i] & ~req_q[i]`, set `pending[i]`. A port held high through reset release counts as one edge.
- FSM states: IDLE, OFFER, SERVICE, HOLDOFF. Reset state is IDLE.
- IDLE: if `pending` is nonzero, pick the first set bit searching upward from `rr_ptr` with wrap-around. Load `grant_port` and go to OFFER. Clear the timeout counter.
- OFFER:
  - `claim` goes to SERVICE.
  - Otherwise, after TIMEOUT_CYCLES cycles in OFFER, go to IDLE. The pending bit is kept, `rr_ptr` is set to grant_port+1 (mod PORT_COUNT), and `timeout_count` increments, saturating at 255.
  - `done` is ignored in OFFER. `claim` and `done` in the same cycle count as `claim` only.
- SERVICE: `done` clears `pending[grant_port]`, sets `rr_ptr` to grant_port+1 (mod), and goes to HOLDOFF, or to IDLE if HOLDOFF_CYCLES=0. `claim` is ignored. There is no timeout in SERVICE.
- HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE.
- Simultaneous set and clear: if a new rising edge on the granted port coincides with `done`, set wins and the bit stays pending.
- Pending bits for other ports keep latching in every state.
- Reset mid-operation clears all state immediately, including any offer or service. Any outstanding CPU handshake is abandoned.
- Reset values:
  - `grant_valid` = 0, `grant_port` = 0, `grant_onehot` = 0.
  - `status_word` = 16'h0000, `pending` = 0, `timeout_count` = 0.
  - `rr_ptr` = 0, `req_q` = 0.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- Request to offer: rising edge sampled at posedge k sets pending. IDLE transitions at posedge k+1, so `grant_valid` is high after k+1. That is 2 cycles minimum from an idle, empty start.
- A claim sampled at posedge m sets `status_word[14]` after m.
- A done sampled at posedge n drops `grant_valid` after n.
- The next offer comes no earlier than n+HOLDOFF_CYCLES+1.
- A timeout withdraws the offer after exactly TIMEOUT_CYCLES posedges in OFFER without a claim. The next offer follows one cycle later.

## Structure
- Package `mmio_sched_pkg`: state enum `sched_state_t`, localparam `PORT_COUNT`, and status-word bit positions (`STAT_VALID_BIT`=15, `STAT_SERVICE_BIT`=14).
- Sub-module `rr_priority_picker`: combinational find-first-set over PORT_COUNT bits starting at a pointer. It outputs `found` and `index`.
- Top-level contents: edge detect, pending register, FSM, and counters.

## Test plan
- Reset, then `port_req`=4'b0100 (PORT_EXPONENT=2) -> `grant_valid`=1 and `grant_port`=2 two cycles after the edge. Claim, then done -> `pending`=0, followed by 2 holdoff cycles.
- Reset, then requests 0, 1 and 3 raised together -> grants in order 0, 1, 3. Then re-raise port 0 -> next grant is 0. This checks wrap-around.
- Offer port 1 with no claim and TIMEOUT_CYCLES=4 -> `grant_valid` drops after 4 cycles, `timeout_count`=1, and a pending port 2 is offered next. Without a port 2 request, port 1 is re-offered.
- In SERVICE on port 3, a new port 3 rising edge in the same cycle as `done` -> `pending[3]` stays 1, and port 3 is re-offered after holdoff.
- In OFFER, `claim` and `done` in the same cycle -> state is SERVICE and `pending` is unchanged. `done` in OFFER alone has no effect.
- Assert `rst` mid-SERVICE -> the cycle after, all outputs are 0. A `port_req` held high through reset release produces a new offer.
